// File: rtl/soc_interval_timer_gen2.sv
// Interval timer with runtime period, clock prescaler, counter snapshot and
// saturating missed-timeout count, exposed as a 16-bit Avalon-MM slave.
module soc_interval_timer_gen2 #(
   parameter int          WIDTH          = 32,
   parameter int          PRESCALE_W     = 16,
   parameter logic [63:0] DEFAULT_PERIOD = 64'd99
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        timeout_pulse
);

   localparam logic [WIDTH-1:0] DEF_PERIOD = DEFAULT_PERIOD[WIDTH-1:0];

   logic                  wr;
   logic                  wr_status, wr_control, wr_prescale, wr_period, wr_snap;
   logic [WIDTH-1:0]      period, counter, snapshot, period_wr;
   logic [PRESCALE_W-1:0] prescale, pcount;
   logic                  ito, cont, run, to, force_reload;
   logic [15:0]           missed;
   logic                  tick;
   logic [1:0]            hw_period, hw_snap;
   logic [63:0]           period_ext, snap_ext;
   logic [15:0]           read_mux;

   assign wr          = chipselect & ~write_n;
   assign wr_status   = wr && (address == 4'd0);
   assign wr_control  = wr && (address == 4'd1);
   assign wr_prescale = wr && (address == 4'd2);
   assign wr_period   = wr && (address >= 4'd3) && (address <= 4'd6);
   assign wr_snap     = wr && (address >= 4'd7) && (address <= 4'd10);

   assign hw_period   = 2'(address - 4'd3);
   assign hw_snap     = 2'(address - 4'd7);
   assign tick        = run && (pcount == prescale);
   assign irq         = to & ito;

   // Wide registers are zero-extended to four halfwords so that halfwords
   // above WIDTH read back as 0 for any WIDTH.
   always_comb begin
      period_ext = 64'(period);
      snap_ext   = 64'(snapshot);
      period_wr  = period;
      for (int i = 0; i < WIDTH; i++) begin
         if ((i >> 4) == int'(hw_period))
            period_wr[i] = writedata[i[3:0]];
      end
   end

   always_comb begin
      read_mux = 16'h0000;
      case (address)
         4'd0:                      read_mux = {14'b0, run, to};
         4'd1:                      read_mux = {14'b0, cont, ito};
         4'd2:                      read_mux = 16'(prescale);
         4'd3, 4'd4, 4'd5, 4'd6:    read_mux = period_ext[{hw_period, 4'b0000} +: 16];
         4'd7, 4'd8, 4'd9, 4'd10:   read_mux = snap_ext[{hw_snap, 4'b0000} +: 16];
         4'd11:                     read_mux = missed;
         default:                   read_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period        <= DEF_PERIOD;
         counter       <= DEF_PERIOD;
         snapshot      <= '0;
         prescale      <= '0;
         pcount        <= '0;
         ito           <= 1'b0;
         cont          <= 1'b0;
         run           <= 1'b0;
         to            <= 1'b0;
         missed        <= 16'h0000;
         force_reload  <= 1'b0;
         readdata      <= 16'h0000;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;

         // A pending reload takes the place of any tick in that cycle.
         if (force_reload) begin
            counter <= period;
            pcount  <= '0;
         end else if (tick) begin
            pcount <= '0;
            if (counter != '0) begin
               counter <= counter - WIDTH'(1);
            end else begin
               counter       <= period;
               timeout_pulse <= 1'b1;
               if (!cont)
                  run <= 1'b0;
            end
         end else if (run) begin
            pcount <= pcount + PRESCALE_W'(1);
         end

         if (wr_control) begin
            ito  <= writedata[0];
            cont <= writedata[1];
            if (writedata[2])
               run <= 1'b1;
            else if (writedata[3])
               run <= 1'b0;
         end
         if (force_reload)
            run <= 1'b0;

         force_reload <= wr_period;
         if (wr_period)
            period <= period_wr;
         if (wr_prescale)
            prescale <= writedata[PRESCALE_W-1:0];
         if (wr_snap)
            snapshot <= counter;

         // The registered pulse is the timeout event; it beats a STATUS clear.
         if (timeout_pulse) begin
            to <= 1'b1;
            if (wr_status)
               missed <= 16'h0000;
            else if (to && (missed != 16'hFFFF))
               missed <= missed + 16'd1;
         end else if (wr_status) begin
            to     <= 1'b0;
            missed <= 16'h0000;
         end

         readdata <= read_mux;
      end
   end

endmodule

// File: doc/soc_interval_timer_gen2.md
Name: soc_interval_timer_gen2

Overview:
Parametrised successor to the fixed-period 16-bit-bus interval timer, used for Nios II system tick and periodic triggers.
- Adds a runtime-writable period of WIDTH bits, a clock prescaler and a snapshot of the live counter.
- Adds a saturating missed-timeout counter and a one-cycle timeout pulse output for hardware triggering.
- Sits on the Avalon-MM peripheral bus as a slave with 16-bit data.

Parameters:
WIDTH, 32, counter/period/snapshot width (1..64)
PRESCALE_W, 16, prescaler register width (1..16)
DEFAULT_PERIOD, 99, period and counter value after reset (must fit WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
address  in  4  register halfword index
chipselect  in  1  slave select
write_n  in  1  active-low write strobe (valid with chipselect)
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  interrupt request, level
timeout_pulse  out  1  one-cycle pulse per timeout event, independent of ITO

Behaviour:
Write strobe: wr = chipselect & ~write_n.
Register map:
- 0 STATUS: bit0 TO, bit1 RUN (read-only). Any write clears TO and MISSED.
- 1 CONTROL: bit0 ITO, bit1 CONT, stored. bit2 START, bit3 STOP are write-only strobes and read 0.
- 2 PRESCALE: low PRESCALE_W bits stored.
- 3..6 PERIOD halfwords 0..3. Bits above WIDTH are ignored on write and read 0.
- 7..10 SNAP halfwords 0..3. A write to any of these captures the counter; bits above WIDTH read 0.
- 11 MISSED: 16-bit count, read-only.
- 12..15: read 0, writes ignored.

Reset values:
- counter = period = DEFAULT_PERIOD.
- prescale, prescale count, control, TO, RUN, snapshot, MISSED, force_reload = 0.
- readdata = 0, irq = 0, timeout_pulse = 0.

Read timing: readdata <= mux(address) every cycle, regardless of chipselect. One-cycle latency; reads have no side effects.

Prescaler:
- tick = RUN & (pcount == prescale). On tick, pcount <= 0; while RUN and not tick, pcount increments.
- prescale = 0 gives a tick every cycle.
- Timeout interval = (period+1)*(prescale+1) cycles.

Counter:
- On tick with counter != 0: decrement.
- On tick with counter == 0: reload period, raise the timeout event, and clear RUN if CONT = 0.
- One-shot mode therefore stops with counter = period.

Period write:
- Updates the addressed halfword at the write edge.
- The next cycle, force_reload: counter <= period (updated value), pcount <= 0, RUN <= 0.
- No timeout event is raised on reload.

START/STOP:
- START sets RUN; counting resumes from the current counter value. START while RUN has no effect on counter or pcount.
- STOP clears RUN; counter and pcount hold.
- START and STOP in the same write: START wins.
- force_reload overrides START in the same cycle: RUN is cleared.

Timeout event:
- timeout_pulse = 1 for exactly that cycle (registered: asserted the cycle after the reload tick).
- TO <= 1 on the event.
- If TO was already 1, MISSED increments, saturating at 0xFFFF.
- STATUS write in the same cycle as an event: event wins. TO ends at 1 and MISSED ends at 0 (cleared, not incremented).

irq = TO & ITO, from registered bits. It follows TO or ITO changes with no added latency.

Snapshot: captures the counter value present at the write edge. Reads are stable until the next snap write.

reset asserted mid-count: all state returns to reset values on that edge. The period register also returns to DEFAULT_PERIOD.

Test Plan:
- Reset, read addr 0/1/3/4 -> readdata 0x0000, 0x0000, 0x0063, 0x0000 one cycle after each address; irq = 0, timeout_pulse = 0.
- Write PERIOD = 9, PRESCALE = 0, CONTROL = 0x7 (ITO|CONT|START) -> timeout_pulse every 10 cycles; irq rises one cycle after the first pulse and stays high; a STATUS write drops irq next cycle.
- Period 4, PRESCALE = 2, CONTROL = 0x4 (one-shot) -> single pulse 15 cycles after start; RUN = 0; counter = 4; no further pulses.
- Continuous run without clearing TO for 4 timeouts -> MISSED = 3. Then a STATUS write coinciding with the 5th event -> TO = 1, MISSED = 0.
- WIDTH = 48: write PERIOD halfwords 0x0000/0x0000/0x0001, start, snap after 5 ticks -> SNAP reads 0xFFFB/0xFFFF/0x0000. SNAP3 and PERIOD3 read 0.
- Write CONTROL = 0xC while stopped -> RUN = 1. Then period write while running -> RUN = 0 two cycles later, counter = new period, no pulse.
